uart_loopback_engine: RTL and testbench

//  Hardware echo stage between the UART RX FIFO and TX FIFO. It pops each received byte,

---
 rtl/uart_loopback_engine.sv | 126 ++++++++++++
 tb/tb_uart_loopback_engine.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_engine.sv
// Hardware echo stage: pops bytes from the UART RX FIFO, optionally upper-cases them and
// expands CR into CR LF, then pushes them into the TX FIFO under the TX full flag.
module uart_loopback_engine #(
    parameter bit          CR_EXPAND   = 1'b1,
    parameter bit          UPPERCASE   = 1'b0,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear_count,
    input  logic [7:0]             rx_data_in,
    input  logic                   rx_data_present,
    output logic                   rx_read_ack,
    output logic [7:0]             tx_data_out,
    output logic                   tx_write,
    input  logic                   tx_buffer_full,
    output logic                   busy,
    output logic                   tx_stall,
    output logic [COUNT_WIDTH-1:0] byte_count
);

    typedef enum logic [1:0] {StIdle, StSend, StLf, StGap} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             byte_q, byte_d;
    logic                   pend_lf_q, pend_lf_d;
    logic                   ack_q, ack_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_write_q, tx_write_d;
    logic                   busy_q, busy_d;
    logic                   stall_q, stall_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // Lower-case ASCII letters map to upper case when UPPERCASE is set.
    function automatic logic [7:0] xform(input logic [7:0] b);
        if (UPPERCASE && (b >= 8'h61) && (b <= 8'h7A)) begin
            return b - 8'h20;
        end
        return b;
    endfunction

    // Next-state and registered-output logic for the pop/push sequencer.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        pend_lf_d  = pend_lf_q;
        ack_d      = 1'b0;
        tx_data_d  = tx_data_q;
        tx_write_d = 1'b0;
        stall_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && rx_data_present) begin
                    byte_d    = xform(rx_data_in);
                    pend_lf_d = CR_EXPAND && (rx_data_in == 8'h0D);
                    ack_d     = 1'b1;
                    state_d   = StSend;
                end
            end
            StSend, StLf: begin
                if (!tx_buffer_full) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = (state_q == StLf) ? 8'h0A : byte_q;
                    state_d    = StGap;
                end else begin
                    stall_d = 1'b1;
                end
            end
            StGap: begin
                // Idle cycle lets the TX full flag catch up with the push just made.
                if (pend_lf_q) begin
                    pend_lf_d = 1'b0;
                    state_d   = StLf;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // Byte counter: counts each cycle tx_write is high; clear has priority.
    always_comb begin
        count_d = count_q;
        if (clear_count) begin
            count_d = '0;
        end else if (tx_write_q) begin
            count_d = count_q + 1'b1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            byte_q     <= 8'h00;
            pend_lf_q  <= 1'b0;
            ack_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_write_q <= 1'b0;
            busy_q     <= 1'b0;
            stall_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            pend_lf_q  <= pend_lf_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            tx_write_q <= tx_write_d;
            busy_q     <= busy_d;
            stall_q    <= stall_d;
            count_q    <= count_d;
        end
    end

    assign rx_read_ack = ack_q;
    assign tx_data_out = tx_data_q;
    assign tx_write    = tx_write_q;
    assign busy        = busy_q;
    assign tx_stall    = stall_q;
    assign byte_count  = count_q;

endmodule

// File: tb/tb_uart_loopback_engine.sv
// Directed bench: instance A uses default parameters, instance B has UPPERCASE=1,
// CR_EXPAND=0, COUNT_WIDTH=4. A small RX FIFO model is popped by A's ack.
module tb_uart_loopback_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clear_count = 1'b0;
    logic       tx_buffer_full = 1'b0;
    logic [7:0] rx_data_in = 8'h00;
    logic       rx_data_present = 1'b0;

    logic        ack_a, wr_a, busy_a, stall_a;
    logic [7:0]  txd_a;
    logic [15:0] cnt_a;
    logic        ack_b, wr_b, busy_b, stall_b;
    logic [7:0]  txd_b;
    logic [3:0]  cnt_b;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int acks_a  = 0;

    logic [7:0] rxq[$];
    logic [7:0] wa_d[$];
    int         wa_c[$];
    logic [7:0] wb_d[$];
    int         wb_c[$];

    uart_loopback_engine dut_a (
        .clk(clk), .reset(reset), .enable(enable), .clear_count(clear_count),
        .rx_data_in(rx_data_in), .rx_data_present(rx_data_present), .rx_read_ack(ack_a),
        .tx_data_out(txd_a), .tx_write(wr_a), .tx_buffer_full(tx_buffer_full),
        .busy(busy_a), .tx_stall(stall_a), .byte_count(cnt_a)
    );

    uart_loopback_engine #(.CR_EXPAND(1'b0), .UPPERCASE(1'b1), .COUNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .clear_count(clear_count),
        .rx_data_in(rx_data_in), .rx_data_present(rx_data_present), .rx_read_ack(ack_b),
        .tx_data_out(txd_b), .tx_write(wr_b), .tx_buffer_full(tx_buffer_full),
        .busy(busy_b), .tx_stall(stall_b), .byte_count(cnt_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RX FIFO model and TX write logger, evaluated mid-cycle to stay clear of the edges.
    always @(negedge clk) begin
        if (ack_a === 1'b1) begin
            if (rxq.size() != 0) void'(rxq.pop_front());
            acks_a = acks_a + 1;
        end
        if (wr_a === 1'b1) begin
            wa_d.push_back(txd_a);
            wa_c.push_back(cyc);
        end
        if (wr_b === 1'b1) begin
            wb_d.push_back(txd_b);
            wb_c.push_back(cyc);
        end
        rx_data_present = (rxq.size() != 0);
        rx_data_in      = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        enable = 1'b0;
        clear_count = 1'b0;
        tx_buffer_full = 1'b0;
        rxq.delete();
        wa_d.delete();
        wa_c.delete();
        wb_d.delete();
        wb_c.delete();
        acks_a = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        vectors++;
        if ({ack_a, wr_a, busy_a, stall_a, txd_a, cnt_a} !== 28'h0) begin
            errors++;
            $display("FAIL reset_a got ack=%b wr=%b busy=%b stall=%b txd=%h cnt=%h want all 0",
                     ack_a, wr_a, busy_a, stall_a, txd_a, cnt_a);
        end
        vectors++;
        if ({ack_b, wr_b, busy_b, stall_b, txd_b, cnt_b} !== 16'h0) begin
            errors++;
            $display("FAIL reset_b got ack=%b wr=%b busy=%b stall=%b txd=%h cnt=%h want all 0",
                     ack_b, wr_b, busy_b, stall_b, txd_b, cnt_b);
        end
    endtask

    task automatic test_single_byte();
        apply_reset();
        enable = 1'b1;
        rxq.push_back(8'h41);
        tick();
        vectors++;
        if (ack_a !== 1'b1 || wr_a !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got ack=%b wr=%b want ack=1 wr=0", ack_a, wr_a);
        end
        tick();
        vectors++;
        if (ack_a !== 1'b0 || wr_a !== 1'b1 || txd_a !== 8'h41 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL single_write got ack=%b wr=%b txd=%h busy=%b want 0 1 41 1",
                     ack_a, wr_a, txd_a, busy_a);
        end
        tick();
        vectors++;
        if (wr_a !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 16'd1) begin
            errors++;
            $display("FAIL single_done got wr=%b busy=%b cnt=%0d want 0 0 1", wr_a, busy_a, cnt_a);
        end
    endtask

    task automatic test_cr_expand();
        apply_reset();
        enable = 1'b1;
        rxq.push_back(8'h0D);
        tick();
        tick();
        vectors++;
        if (wr_a !== 1'b1 || txd_a !== 8'h0D) begin
            errors++;
            $display("FAIL cr_first got wr=%b txd=%h want 1 0d", wr_a, txd_a);
        end
        tick();
        vectors++;
        if (wr_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL cr_gap got wr=%b busy=%b want 0 1", wr_a, busy_a);
        end
        tick();
        vectors++;
        if (wr_a !== 1'b1 || txd_a !== 8'h0A) begin
            errors++;
            $display("FAIL cr_lf got wr=%b txd=%h want 1 0a", wr_a, txd_a);
        end
        tick();
        vectors++;
        if (busy_a !== 1'b0 || cnt_a !== 16'd2 || acks_a != 1) begin
            errors++;
            $display("FAIL cr_done got busy=%b cnt=%0d acks=%0d want 0 2 1", busy_a, cnt_a, acks_a);
        end
    endtask

    task automatic test_uppercase();
        logic [7:0] exp_b[4];
        exp_b = '{8'h41, 8'h5A, 8'h7B, 8'h40};
        apply_reset();
        enable = 1'b1;
        rxq.push_back(8'h61);
        rxq.push_back(8'h7A);
        rxq.push_back(8'h7B);
        rxq.push_back(8'h40);
        repeat (14) tick();
        vectors++;
        if (wb_d.size() != 4) begin
            errors++;
            $display("FAIL upper_count got %0d writes want 4", wb_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (wb_d[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL upper_byte%0d got %h want %h", i, wb_d[i], exp_b[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (wb_c[i+1] - wb_c[i] != 3) begin
                    errors++;
                    $display("FAIL upper_spacing%0d got %0d want 3", i, wb_c[i+1] - wb_c[i]);
                end
            end
        end
        vectors++;
        if (wa_d.size() != 4 || wa_d[0] !== 8'h61) begin
            errors++;
            $display("FAIL upper_off got size=%0d first=%h want 4 61", wa_d.size(),
                     (wa_d.size() != 0) ? wa_d[0] : 8'hxx);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        tx_buffer_full = 1'b1;
        enable = 1'b1;
        rxq.push_back(8'h55);
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (stall_a !== 1'b1 || wr_a !== 1'b0) begin
                errors++;
                $display("FAIL stall_c%0d got stall=%b wr=%b want 1 0", i, stall_a, wr_a);
            end
        end
        tx_buffer_full = 1'b0;
        tick();
        vectors++;
        if (wr_a !== 1'b1 || txd_a !== 8'h55 || stall_a !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got wr=%b txd=%h stall=%b want 1 55 0",
                     wr_a, txd_a, stall_a);
        end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        enable = 1'b1;
        rxq.push_back(8'h0D);
        rxq.push_back(8'h31);
        tick();
        enable = 1'b0;
        repeat (8) tick();
        vectors++;
        if (wa_d.size() != 2) begin
            errors++;
            $display("FAIL drop_writes got %0d writes want 2", wa_d.size());
        end else begin
            vectors++;
            if (wa_d[0] !== 8'h0D || wa_d[1] !== 8'h0A) begin
                errors++;
                $display("FAIL drop_bytes got %h %h want 0d 0a", wa_d[0], wa_d[1]);
            end
        end
        vectors++;
        if (acks_a != 1 || busy_a !== 1'b0 || rxq.size() != 1) begin
            errors++;
            $display("FAIL drop_idle got acks=%0d busy=%b rxleft=%0d want 1 0 1",
                     acks_a, busy_a, rxq.size());
        end
    endtask

    task automatic test_count_wrap_clear_reset();
        apply_reset();
        enable = 1'b1;
        for (int i = 0; i < 16; i++) rxq.push_back(8'h30 + 8'(i));
        repeat (52) tick();
        vectors++;
        if (cnt_b !== 4'd0 || wb_d.size() != 16 || cnt_a !== 16'd16) begin
            errors++;
            $display("FAIL wrap got cnt_b=%0d writes=%0d cnt_a=%0d want 0 16 16",
                     cnt_b, wb_d.size(), cnt_a);
        end
        // clear_count coinciding with a write
        apply_reset();
        enable = 1'b1;
        rxq.push_back(8'h42);
        tick();
        tick();
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        vectors++;
        if (cnt_a !== 16'd0) begin
            errors++;
            $display("FAIL clear_on_write got cnt=%0d want 0", cnt_a);
        end
        rxq.push_back(8'h43);
        repeat (3) tick();
        vectors++;
        if (cnt_a !== 16'd1 || txd_a !== 8'h43) begin
            errors++;
            $display("FAIL after_clear got cnt=%0d txd=%h want 1 43", cnt_a, txd_a);
        end
        tx_buffer_full = 1'b1;
        rxq.push_back(8'h44);
        tick();
        tick();
        vectors++;
        if (stall_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got stall=%b busy=%b want 1 1", stall_a, busy_a);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({ack_a, wr_a, busy_a, stall_a, txd_a, cnt_a} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset got ack=%b wr=%b busy=%b stall=%b txd=%h cnt=%h want all 0",
                     ack_a, wr_a, busy_a, stall_a, txd_a, cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_cr_expand();
        test_uppercase();
        test_stall();
        test_enable_drop();
        test_count_wrap_clear_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no completion want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
